// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: drives the instruction memory request, presents one instruction per cycle
// to IF/ID, buffers one instruction under stall and discards responses orphaned by a redirect.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_plus_4,
    output logic [31:0] IR,
    output logic        fetch_valid
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_FULL  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [XLEN-1:0]   r_pc_q;
    logic [XLEN-1:0]   r_buf_ir;
    logic [XLEN-1:0]   r_buf_pcp4;
    logic [XLEN-1:0]   r_stale_addr;
    logic [XLEN-1:0]   w_pc_nxt;
    logic [XLEN-1:0]   w_buf_ir_nxt;
    logic [XLEN-1:0]   w_buf_pcp4_nxt;
    logic [XLEN-1:0]   w_stale_nxt;
    logic [XLEN-1:0]   w_pc_inc;

    assign w_pc_inc = r_pc_q + XLEN'(4);

    // State and buffer registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_FETCH;
            r_pc_q       <= RESET_PC;
            r_buf_ir     <= '0;
            r_buf_pcp4   <= RESET_PC;
            r_stale_addr <= RESET_PC;
        end else begin
            r_state      <= w_state_nxt;
            r_pc_q       <= w_pc_nxt;
            r_buf_ir     <= w_buf_ir_nxt;
            r_buf_pcp4   <= w_buf_pcp4_nxt;
            r_stale_addr <= w_stale_nxt;
        end
    end

    // Next-state, memory request and presented-instruction logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc_q;
        w_buf_ir_nxt   = r_buf_ir;
        w_buf_pcp4_nxt = r_buf_pcp4;
        w_stale_nxt    = r_stale_addr;
        imem_req       = 1'b0;
        imem_addr      = r_pc_q;
        IR             = '0;
        PC_plus_4      = RESET_PC;
        fetch_valid    = 1'b0;

        unique case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (redirect_valid) begin
                    w_pc_nxt = redirect_target;
                    if (!imem_ack) begin
                        w_stale_nxt = r_pc_q;
                        w_state_nxt = S_DRAIN;
                    end
                end else if (imem_ack) begin
                    IR          = imem_rdata;
                    PC_plus_4   = w_pc_inc;
                    fetch_valid = 1'b1;
                    w_pc_nxt    = w_pc_inc;
                    if (stall_in) begin
                        w_buf_ir_nxt   = imem_rdata;
                        w_buf_pcp4_nxt = w_pc_inc;
                        w_state_nxt    = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (redirect_valid) begin
                    w_pc_nxt    = redirect_target;
                    w_state_nxt = S_FETCH;
                end else begin
                    IR          = r_buf_ir;
                    PC_plus_4   = r_buf_pcp4;
                    fetch_valid = 1'b1;
                    if (!stall_in) begin
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_DRAIN: begin
                // The outstanding response belongs to the abandoned path and is never presented.
                imem_req  = 1'b1;
                imem_addr = r_stale_addr;
                if (redirect_valid) begin
                    w_pc_nxt = redirect_target;
                end
                if (imem_ack) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase

        if (!reset) begin
            imem_req    = 1'b0;
            IR          = '0;
            PC_plus_4   = RESET_PC;
            fetch_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: inputs driven on the falling edge, outputs checked 1ns later.
module tb_if_fetch_unit;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk;
    logic        reset;
    logic        stall_in;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] PC_plus_4;
    logic [31:0] IR;
    logic        fetch_valid;

    int n_checks;
    int n_errors;

    if_fetch_unit #(.RESET_PC(RPC)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall_in        (stall_in),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .PC_plus_4       (PC_plus_4),
        .IR              (IR),
        .fetch_valid     (fetch_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle of stimulus; outputs are settled 1ns after the falling edge.
    task automatic drv(input logic rst, input logic stall, input logic redir,
                       input logic [31:0] tgt, input logic ack, input logic [31:0] rdata);
        @(negedge clk);
        reset           = rst;
        stall_in        = stall;
        redirect_valid  = redir;
        redirect_target = tgt;
        imem_ack        = ack;
        imem_rdata      = rdata;
        #1;
    endtask

    task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                           input logic vld, input logic [31:0] ir, input logic [31:0] pcp4);
        chk({tag, ".req"},  32'(imem_req),    32'(req));
        if (req) chk({tag, ".addr"}, imem_addr, addr);
        chk({tag, ".vld"},  32'(fetch_valid), 32'(vld));
        chk({tag, ".ir"},   IR,               ir);
        chk({tag, ".pcp4"}, PC_plus_4,        pcp4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0; stall_in = 1'b0; redirect_valid = 1'b0;
        redirect_target = '0; imem_ack = 1'b0; imem_rdata = '0;

        // Held in reset: no request, bubble even with a stray ack.
        drv(0, 0, 0, 0, 1, 32'h1234_5678);
        chk_out("rst0", 0, RPC, 0, 32'h0, RPC);
        drv(0, 0, 0, 0, 1, 32'h1234_5678);
        chk_out("rst1", 0, RPC, 0, 32'h0, RPC);

        // Zero-wait streaming.
        drv(1, 0, 0, 0, 1, 32'h1111_1111);
        chk_out("zw0", 1, 32'h0040_0000, 1, 32'h1111_1111, 32'h0040_0004);
        drv(1, 0, 0, 0, 1, 32'h2222_2222);
        chk_out("zw1", 1, 32'h0040_0004, 1, 32'h2222_2222, 32'h0040_0008);
        drv(1, 0, 0, 0, 1, 32'h3333_3333);
        chk_out("zw2", 1, 32'h0040_0008, 1, 32'h3333_3333, 32'h0040_000C);

        // Stall captures the word fetched at 0x00400004.
        drv(0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 1, 32'h1111_1111);
        chk_out("st0", 1, 32'h0040_0000, 1, 32'h1111_1111, 32'h0040_0004);
        drv(1, 1, 0, 0, 1, 32'hDEAD_BEEF);
        chk_out("st1", 1, 32'h0040_0004, 1, 32'hDEAD_BEEF, 32'h0040_0008);
        for (int i = 0; i < 3; i++) begin
            drv(1, 1, 0, 0, 0, 0);
            chk_out("full", 0, 0, 1, 32'hDEAD_BEEF, 32'h0040_0008);
        end
        drv(1, 0, 0, 0, 0, 0);
        chk_out("fullrel", 0, 0, 1, 32'hDEAD_BEEF, 32'h0040_0008);
        drv(1, 0, 0, 0, 0, 0);
        chk_out("afterfull", 1, 32'h0040_0008, 0, 32'h0, RPC);

        // One-cycle reset while FULL.
        drv(1, 1, 0, 0, 1, 32'hCAFE_0001);
        chk_out("tofull", 1, 32'h0040_0008, 1, 32'hCAFE_0001, 32'h0040_000C);
        drv(0, 1, 0, 0, 0, 0);
        chk_out("rstfull", 0, 0, 0, 32'h0, RPC);
        drv(1, 0, 0, 0, 0, 0);
        chk_out("postrst", 1, 32'h0040_0000, 0, 32'h0, RPC);
        drv(1, 0, 0, 0, 1, 32'hCAFE_0002);
        chk_out("postrstack", 1, 32'h0040_0000, 1, 32'hCAFE_0002, 32'h0040_0004);

        // Redirect on first wait cycle of a 2-wait-state access.
        drv(0, 0, 0, 0, 0, 0);
        drv(1, 0, 1, 32'h0040_0100, 0, 0);
        chk_out("dr0", 1, 32'h0040_0000, 0, 32'h0, RPC);
        drv(1, 0, 0, 0, 0, 0);
        chk_out("dr1", 1, 32'h0040_0000, 0, 32'h0, RPC);
        drv(1, 0, 0, 0, 1, 32'hBAD0_BAD0);
        chk_out("dr2", 1, 32'h0040_0000, 0, 32'h0, RPC);
        drv(1, 0, 0, 0, 0, 0);
        chk_out("dr3", 1, 32'h0040_0100, 0, 32'h0, RPC);

        // Two redirects while draining: latest target wins, stale address held.
        drv(1, 0, 1, 32'h0040_0180, 0, 0);
        chk_out("dd0", 1, 32'h0040_0100, 0, 32'h0, RPC);
        drv(1, 0, 1, 32'h0040_0200, 0, 0);
        chk_out("dd1", 1, 32'h0040_0100, 0, 32'h0, RPC);
        drv(1, 0, 1, 32'h0040_0300, 0, 0);
        chk_out("dd2", 1, 32'h0040_0100, 0, 32'h0, RPC);
        drv(1, 0, 0, 0, 1, 32'hBAD1_BAD1);
        chk_out("dd3", 1, 32'h0040_0100, 0, 32'h0, RPC);
        drv(1, 0, 0, 0, 0, 0);
        chk_out("dd4", 1, 32'h0040_0300, 0, 32'h0, RPC);

        // Redirect with ack drops the response; then wrap past 0xFFFFFFFC.
        drv(1, 0, 1, 32'hFFFF_FFFC, 1, 32'hBAD2_BAD2);
        chk_out("wr0", 1, 32'h0040_0300, 0, 32'h0, RPC);
        drv(1, 0, 0, 0, 1, 32'h5555_0001);
        chk_out("wr1", 1, 32'hFFFF_FFFC, 1, 32'h5555_0001, 32'h0000_0000);
        drv(1, 0, 0, 0, 1, 32'h5555_0002);
        chk_out("wr2", 1, 32'h0000_0000, 1, 32'h5555_0002, 32'h0000_0004);

        // Redirect in FULL invalidates the buffer; unaligned target kept as given.
        drv(1, 1, 0, 0, 1, 32'h6666_0001);
        chk_out("rf0", 1, 32'h0000_0004, 1, 32'h6666_0001, 32'h0000_0008);
        drv(1, 1, 1, 32'h0000_1003, 0, 0);
        chk_out("rf1", 0, 0, 0, 32'h0, RPC);
        drv(1, 0, 0, 0, 0, 0);
        chk_out("rf2", 1, 32'h0000_1003, 0, 32'h0, RPC);
        drv(1, 0, 0, 0, 1, 32'h7777_0001);
        chk_out("rf3", 1, 32'h0000_1003, 1, 32'h7777_0001, 32'h0000_1007);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
